// File: rtl/apb_uart_pkg.sv
// Shared types and constants for the APB-to-UART register-file controller.
package apb_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int RF_ADDR_W_DEF = 12;

    localparam logic [11:0] REG_TDR = 12'h000;
    localparam logic [11:0] REG_RDR = 12'h004;
    localparam logic [11:0] REG_LCR = 12'h008;
    localparam logic [11:0] REG_OCR = 12'h00C;
    localparam logic [11:0] REG_LSR = 12'h010;
    localparam logic [11:0] REG_FCR = 12'h014;
    localparam logic [11:0] REG_MSR = 12'h018;
    localparam logic [11:0] REG_MCR = 12'h01C;
    localparam logic [11:0] REG_IER = 12'h020;
    localparam logic [11:0] REG_IIR = 12'h024;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_uart_slave_ctrl.sv
// APB4 slave that turns each bus transfer into one register-file access pulse,
// captures the registered response and completes the transfer with registered outputs.
//
// state    | meaning
// ST_IDLE  | waiting for an APB setup phase
// ST_ISSUE | rf_en_o high for this single cycle
// ST_CAPT  | register-file response valid, captured at the end of the cycle
// ST_WAIT  | optional stall cycles before completion
// ST_DONE  | pready_o high with the captured response
module apb_uart_slave_ctrl
    import apb_uart_pkg::*;
#(
    parameter int PADDR_W        = 32,
    parameter int RF_ADDR_W      = RF_ADDR_W_DEF,
    parameter int WAIT_STATES    = 0,
    parameter bit STRICT_RD_STRB = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [PADDR_W-1:0]   paddr_i,
    input  logic [31:0]          pwdata_i,
    input  logic [3:0]           pstrb_i,
    output logic                 pready_o,
    output logic [31:0]          prdata_o,
    output logic                 pslverr_o,
    output logic                 rf_en_o,
    output logic                 rf_wr_rd_o,
    output logic [RF_ADDR_W-1:0] rf_addr_o,
    output logic [31:0]          rf_wdata_o,
    output logic [3:0]           rf_strb_o,
    input  logic [31:0]          rf_prdata_i,
    input  logic                 rf_addr_err_i,
    output logic                 prot_err_o
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [3:0]  wait_cnt;
    logic        loc_err;
    logic [31:0] capt_rdata;

    always_comb begin
        loc_err = 1'b0;
        if (paddr_i[1:0] != 2'b00)
            loc_err = 1'b1;
        if ((paddr_i >> RF_ADDR_W) != '0)
            loc_err = 1'b1;
        if (STRICT_RD_STRB && !pwrite_i && (pstrb_i != 4'h0))
            loc_err = 1'b1;
    end

    // Write responses carry no data even if the register file drives something.
    assign capt_rdata = rf_wr_rd_o ? 32'h0 : rf_prdata_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            pready_o   <= 1'b0;
            prdata_o   <= '0;
            pslverr_o  <= 1'b0;
            rf_en_o    <= 1'b0;
            rf_wr_rd_o <= 1'b0;
            rf_addr_o  <= '0;
            rf_wdata_o <= '0;
            rf_strb_o  <= '0;
            prot_err_o <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            rf_en_o    <= 1'b0;
            pready_o   <= 1'b0;
            prdata_o   <= '0;
            pslverr_o  <= 1'b0;
            prot_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (psel_i && !penable_i) begin
                        rf_wr_rd_o <= pwrite_i;
                        rf_addr_o  <= paddr_i[RF_ADDR_W-1:0];
                        rf_wdata_o <= pwdata_i;
                        rf_strb_o  <= pwrite_i ? pstrb_i : 4'h0;
                        if (loc_err) begin
                            state     <= ST_DONE;
                            err_q     <= RESP_SLVERR;
                            rdata_q   <= '0;
                            pready_o  <= 1'b1;
                            pslverr_o <= RESP_SLVERR;
                        end else begin
                            state   <= ST_ISSUE;
                            rf_en_o <= 1'b1;
                        end
                    end else if (psel_i && penable_i) begin
                        prot_err_o <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!psel_i) begin
                        state      <= ST_IDLE;
                        prot_err_o <= 1'b1;
                    end else begin
                        state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (!psel_i) begin
                        state      <= ST_IDLE;
                        prot_err_o <= 1'b1;
                    end else begin
                        rdata_q <= capt_rdata;
                        err_q   <= rf_addr_err_i;
                        if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state     <= ST_DONE;
                            pready_o  <= 1'b1;
                            prdata_o  <= capt_rdata;
                            pslverr_o <= rf_addr_err_i;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!psel_i) begin
                        state      <= ST_IDLE;
                        prot_err_o <= 1'b1;
                    end else if (wait_cnt == 4'd0) begin
                        state     <= ST_DONE;
                        pready_o  <= 1'b1;
                        prdata_o  <= rdata_q;
                        pslverr_o <= err_q;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (!psel_i)
                        prot_err_o <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_slave_ctrl.sv
// Scoreboard bench: two controller instances (0 and 3 wait states), each backed
// by a small behavioural register file with ten word registers.
module tb_apb_uart_slave_ctrl;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        psel [2];
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;

    logic        pready [2];
    logic [31:0] prdata [2];
    logic        pslverr [2];
    logic        rf_en [2];
    logic        rf_wr_rd [2];
    logic [11:0] rf_addr [2];
    logic [31:0] rf_wdata [2];
    logic [3:0]  rf_strb [2];
    logic [31:0] rf_prdata [2];
    logic        rf_addr_err [2];
    logic        prot_err [2];

    logic [31:0] regs [2][16];
    exp_t        sb [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    apb_uart_slave_ctrl #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .psel_i(psel[0]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0]),
        .rf_en_o(rf_en[0]), .rf_wr_rd_o(rf_wr_rd[0]), .rf_addr_o(rf_addr[0]),
        .rf_wdata_o(rf_wdata[0]), .rf_strb_o(rf_strb[0]), .rf_prdata_i(rf_prdata[0]),
        .rf_addr_err_i(rf_addr_err[0]), .prot_err_o(prot_err[0])
    );

    apb_uart_slave_ctrl #(.WAIT_STATES(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .psel_i(psel[1]), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1]),
        .rf_en_o(rf_en[1]), .rf_wr_rd_o(rf_wr_rd[1]), .rf_addr_o(rf_addr[1]),
        .rf_wdata_o(rf_wdata[1]), .rf_strb_o(rf_strb[1]), .rf_prdata_i(rf_prdata[1]),
        .rf_addr_err_i(rf_addr_err[1]), .prot_err_o(prot_err[1])
    );

    // Register file: offsets 0x000..0x024 exist, anything else flags an address error.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                rf_prdata[i]   <= '0;
                rf_addr_err[i] <= 1'b0;
                for (int r = 0; r < 16; r++) regs[i][r] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rf_en[i]) begin
                    if (rf_addr[i][1:0] == 2'b00 && rf_addr[i][11:2] < 10'd10) begin
                        rf_addr_err[i] <= 1'b0;
                        if (rf_wr_rd[i]) begin
                            rf_prdata[i] <= '0;
                            for (int b = 0; b < 4; b++)
                                if (rf_strb[i][b])
                                    regs[i][rf_addr[i][5:2]][8*b +: 8] <= rf_wdata[i][8*b +: 8];
                        end else begin
                            rf_prdata[i] <= regs[i][rf_addr[i][5:2]];
                        end
                    end else begin
                        rf_addr_err[i] <= 1'b1;
                        rf_prdata[i]   <= '0;
                    end
                end
            end
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: every completion must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (pready[i] === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("pready_unexpected", 32'(pready[i]), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_dut", 32'(i), 32'(e.dut));
                        chk("resp_prdata", prdata[i], e.rdata);
                        chk("resp_pslverr", 32'(pslverr[i]), 32'(e.err));
                        chk("resp_latency", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        psel[0] = 1'b0;
        psel[1] = 1'b0;
        penable = 1'b0;
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int lat, input int exp_en);
        exp_t e;
        int   n_en;
        bit   got;
        @(negedge clk);
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        e.dut   = d;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.cyc   = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        penable = 1'b1;
        // Bus changes after setup must not affect the transfer.
        paddr  = 32'hDEAD_BEEE;
        pwdata = 32'h1234_5678;
        if (exp_en != 0) begin
            chk("rf_addr", 32'(rf_addr[d]), {20'h0, addr[11:0]});
            chk("rf_wr_rd", 32'(rf_wr_rd[d]), 32'(wr));
            chk("rf_strb", 32'(rf_strb[d]), wr ? 32'(strb) : 32'd0);
            if (wr) chk("rf_wdata", rf_wdata[d], wdata);
        end
        n_en = 0;
        got  = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (rf_en[d] === 1'b1) n_en++;
            if (pready[d] === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) chk("timeout_pready", 32'(pready[d]), 32'd1);
        chk("rf_en_pulses", 32'(n_en), 32'(exp_en));
    endtask

    initial begin
        psel[0] = 1'b0;
        psel[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pready", 32'(pready[0]), 32'd0);
        chk("rst_prdata", prdata[0], 32'd0);
        chk("rst_pslverr", 32'(pslverr[0]), 32'd0);
        chk("rst_rf_en", 32'(rf_en[0]), 32'd0);
        chk("rst_prot_err", 32'(prot_err[1]), 32'd0);
        chk("rst_rf_addr", 32'(rf_addr[1]), 32'd0);
        reset_n = 1'b1;
        idle();

        // Write LCR then back-to-back read of LCR
        xfer(0, 1'b1, 32'h008, 32'h0000_0083, 4'hF, 1'b0, 32'h0, 3, 1);
        xfer(0, 1'b0, 32'h008, 32'h0, 4'h0, 1'b0, 32'h0000_0083, 3, 1);
        // Non-existent register
        xfer(0, 1'b0, 32'h028, 32'h0, 4'h0, 1'b1, 32'h0, 3, 1);
        // Local errors: misaligned, read strobe, out of range
        xfer(0, 1'b1, 32'h006, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1, 0);
        xfer(0, 1'b0, 32'h00C, 32'h0, 4'h1, 1'b1, 32'h0, 1, 0);
        xfer(0, 1'b0, 32'h1008, 32'h0, 4'h0, 1'b1, 32'h0, 1, 0);
        idle();

        // Abort during CAPT of a read
        @(negedge clk);
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h00C; pstrb = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel[0] = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_prot_err", 32'(prot_err[0]), 32'd1);
        @(negedge clk);
        chk("abort_prot_err_clear", 32'(prot_err[0]), 32'd0);
        repeat (3) @(negedge clk);
        xfer(0, 1'b0, 32'h008, 32'h0, 4'h0, 1'b0, 32'h0000_0083, 3, 1);
        idle();

        // Access phase without a setup phase
        @(negedge clk);
        psel[0] = 1'b1; penable = 1'b1;
        @(negedge clk);
        chk("idle_prot_err", 32'(prot_err[0]), 32'd1);
        psel[0] = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("idle_prot_err_clear", 32'(prot_err[0]), 32'd0);

        // Reset during ISSUE
        @(negedge clk);
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h000;
        pwdata = 32'h0000_00AA; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        chk("mid_rst_issue_rf_en", 32'(rf_en[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rf_en", 32'(rf_en[0]), 32'd0);
        chk("mid_rst_rf_addr_wdata", rf_wdata[0], 32'd0);
        chk("mid_rst_pready", 32'(pready[0]), 32'd0);
        psel[0] = 1'b0; penable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        xfer(0, 1'b1, 32'h000, 32'h0000_0055, 4'hF, 1'b0, 32'h0, 3, 1);
        xfer(0, 1'b0, 32'h000, 32'h0, 4'h0, 1'b0, 32'h0000_0055, 3, 1);
        idle();

        // Three wait states: byte write to IER then read back
        xfer(1, 1'b1, 32'h020, 32'hFFFF_FFA5, 4'h1, 1'b0, 32'h0, 6, 1);
        xfer(1, 1'b0, 32'h020, 32'h0, 4'h0, 1'b0, 32'h0000_00A5, 6, 1);
        idle();

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
